uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Byte buffer and frame sequencer sitting directly upstream of the UART transmitter.
- Accepts bytes from a valid/ready write port into a circular FIFO.
- Presents one byte at a time to the transmitter's start/data inputs and advances on the transmitter's one-cycle done pulse.
- Together with the transmitter, forms the complete TX path; allows software or other logic to burst bytes without tracking baud timing.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- DATA_W, 8, byte width; must match the transmitter data width.

Ports:
- i_clk  input  1  system clock.
- i_aresetn  input  1  asynchronous active-low reset.
- i_wr_valid  input  1  write request.
- i_wr_data  input  DATA_W  byte to enqueue.
- o_wr_ready  output  1  FIFO can accept; a write occurs on a clock edge where i_wr_valid and o_wr_ready are both 1.
- o_tx_start  output  1  to transmitter start input; level, held for the whole frame.
- o_tx_data  output  DATA_W  to transmitter data input; stable while o_tx_start is 1.
- i_tx_done  input  1  one-cycle pulse from the transmitter at end of stop bit.
- o_busy  output  1  a byte is in flight (FSM in SEND).
- o_empty  output  1  FIFO holds no bytes.
- o_full  output  1  FIFO holds DEPTH bytes.
- o_level  output  $clog2(DEPTH)+1  bytes in FIFO, excluding the byte in flight.

Behaviour:
- Reset is i_aresetn, asynchronous, active-low; clock is i_clk.
- Reset values: o_tx_start 0, o_tx_data 0, o_busy 0, o_empty 1, o_full 0, o_level 0, o_wr_ready 1, read/write pointers 0, FSM in IDLE.
- FIFO storage is not reset.
- FIFO:
  - Write and read pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
  - Count register is 0..DEPTH.
  - o_wr_ready = !o_full, combinational from the count.
  - Push and pop in the same cycle leave the count unchanged.
  - A push is impossible when full, because ready is low.
  - A pop happens only when not empty.
- FSM, two states:
  - IDLE: if !o_empty, pop head into o_tx_data, set o_tx_start=1, go to SEND. Otherwise hold o_tx_start=0.
  - SEND: wait for i_tx_done.
    - On i_tx_done with FIFO non-empty: pop next byte into o_tx_data, keep o_tx_start=1, stay in SEND (back-to-back frames, no idle gap beyond the transmitter's own).
    - On i_tx_done with FIFO empty: o_tx_start=0, go to IDLE.
  - i_tx_done while in IDLE is ignored.
- Latency: byte accepted on edge N into an empty FIFO with FSM in IDLE -> o_tx_start=1 and o_tx_data=byte after edge N+1.
- Same-cycle events:
  - A write and i_tx_done in the same cycle with FIFO empty: FSM goes to IDLE; the new byte starts after the next edge (from IDLE).
  - Full FIFO plus i_tx_done: pop occurs, and o_wr_ready rises the following cycle.
- Transmitter contract:
  - The transmitter latches data at its first baud tick while idle with start high, and ignores start during a frame.
  - The baud tick period must be at least 2 clocks, so that no tick coincides with the i_tx_done cycle, during which start is still high with the old byte.
- Reset mid-frame: all outputs return to reset values immediately, and FIFO contents are discarded. The transmitter is reset by the same i_aresetn.

Optional Feature:
- Macro: UART_TX_FEEDER_FLUSH_EN.
- With the macro defined, an extra input i_flush (1 bit, synchronous, active-high) is present:
  - Clears both pointers and count on the next edge.
  - Forces o_wr_ready=0 while high, so a coincident write is dropped.
  - Does not abort the byte in flight: o_tx_start/o_tx_data stay until i_tx_done, then the FSM goes to IDLE because the FIFO is empty.
  - A flush in the same cycle as i_tx_done: no pop occurs, and the FSM goes to IDLE.
- With the macro undefined: the port is absent and no flush logic is generated.

Test Plan:
- Single byte: write 0xA5 after reset -> o_tx_start=1, o_tx_data=0xA5 two edges after the write; o_busy=1; after the i_tx_done pulse, o_tx_start=0 the next cycle and o_level=0.
- Burst: write 0x01..0x05 back-to-back -> o_level peaks at 4 (one byte in flight); the transmitter line carries 0x01..0x05 in order; o_tx_start stays high continuously until the 5th done.
- Full: with i_tx_done held low, write 17 bytes into DEPTH=16 -> after the first byte is popped, 16 more fill the FIFO; o_full=1, o_wr_ready=0, and the 18th write is not accepted. One done pulse -> o_wr_ready=1 the next cycle, o_level=15.
- Wrap: push/pop 40 bytes with a random valid pattern -> output sequence equals input sequence, and pointers wrap twice.
- Reset mid-frame: drop i_aresetn during the 3rd byte of a 6-byte burst -> all outputs at reset values immediately; after release, nothing is transmitted.
- Flush (UART_TX_FEEDER_FLUSH_EN): with 5 queued and 1 in flight, pulse i_flush -> o_level=0 next cycle; the in-flight byte completes; o_tx_start=0 after its done; no further frames.

Source files
------------

// File: rtl/uart_tx_feeder.sv
// Byte FIFO and frame sequencer feeding the UART transmitter start/data inputs.
// Define UART_TX_FEEDER_FLUSH_EN to add the synchronous i_flush input.
module uart_tx_feeder #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 8
) (
  input  logic                       i_clk,
  input  logic                       i_aresetn,
`ifdef UART_TX_FEEDER_FLUSH_EN
  input  logic                       i_flush,
`endif
  input  logic                       i_wr_valid,
  input  logic [DATA_W-1:0]          i_wr_data,
  output logic                       o_wr_ready,
  output logic                       o_tx_start,
  output logic [DATA_W-1:0]          o_tx_data,
  input  logic                       i_tx_done,
  output logic                       o_busy,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            r_state;
  logic              r_tx_start;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;

  logic w_full;
  logic w_empty;
  logic w_wr_ready;
  logic w_push;
  logic w_pop;
  logic w_flush;

`ifdef UART_TX_FEEDER_FLUSH_EN
  assign w_flush = i_flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_full     = (r_count == FULL_CNT);
  assign w_empty    = (r_count == '0);
  assign w_wr_ready = !w_full && !w_flush;
  assign w_push     = i_wr_valid && w_wr_ready;
  // IDLE pops whenever data is present; SEND only on the done pulse.
  // A flush suppresses the pop so an in-flight frame ends into IDLE.
  assign w_pop      = !w_empty && !w_flush && ((r_state == IDLE) || i_tx_done);

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_aresetn) begin
    if (!i_aresetn) begin
      r_state    <= IDLE;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_tx_data  <= r_mem[r_rd_ptr];
            r_tx_start <= 1'b1;
            r_state    <= SEND;
          end else begin
            r_tx_start <= 1'b0;
          end
        end
        SEND: begin
          if (i_tx_done) begin
            if (w_pop) begin
              r_tx_data <= r_mem[r_rd_ptr];
            end else begin
              r_tx_start <= 1'b0;
              r_state    <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_wr_ready = w_wr_ready;
  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = (r_state == SEND);
  assign o_empty    = w_empty;
  assign o_full     = w_full;
  assign o_level    = r_count;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Self-checking bench for uart_tx_feeder: vector table plus scoreboarded transmitter model.
module tb_uart_tx_feeder;

  localparam int FRAME_LEN = 6;

  logic       clk;
  logic       aresetn;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_done;
  logic       busy;
  logic       empty;
  logic       full;
  logic [4:0] level;
  logic       man_done;
  logic       model_done;
  logic       tx_auto;
`ifdef UART_TX_FEEDER_FLUSH_EN
  logic       flush;
`endif

  assign tx_done = man_done | model_done;

  uart_tx_feeder #(.DEPTH(16), .DATA_W(8)) dut (
    .i_clk      (clk),
    .i_aresetn  (aresetn),
`ifdef UART_TX_FEEDER_FLUSH_EN
    .i_flush    (flush),
`endif
    .i_wr_valid (wr_valid),
    .i_wr_data  (wr_data),
    .o_wr_ready (wr_ready),
    .o_tx_start (tx_start),
    .o_tx_data  (tx_data),
    .i_tx_done  (tx_done),
    .o_busy     (busy),
    .o_empty    (empty),
    .o_full     (full),
    .o_level    (level)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int frames   = 0;
  logic [7:0] sb[$];

  typedef struct packed {
    logic        v;
    logic [7:0]  d;
    logic        done;
    logic [17:0] exp;
  } vec_t;

  vec_t tbl[12];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [17:0] outs_now();
    return {tx_start, tx_data, busy, empty, full, level, wr_ready};
  endfunction

  function automatic logic [17:0] mk(input logic s, input logic [7:0] d, input logic b,
                                     input logic e, input logic f, input logic [4:0] l);
    return {s, d, b, e, f, l, ~f};
  endfunction

  // Transmitter model: latches each new frame, compares it with the scoreboard, then pulses done.
  initial begin
    int cnt;
    cnt = 0;
    model_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (model_done) begin
        model_done = 1'b0;
        cnt = 0;
      end
      if (!tx_auto || !tx_start) begin
        cnt = 0;
      end else if (cnt == 0) begin
        frames++;
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL frame_data: got unexpected frame %h expected none", tx_data);
        end else begin
          check("frame_data", {24'd0, tx_data}, {24'd0, sb.pop_front()});
        end
        cnt = 1;
      end else if (cnt == FRAME_LEN - 1) begin
        model_done = 1'b1;
      end else begin
        cnt++;
      end
    end
  end

  task automatic write_byte(input logic [7:0] d, output bit acc);
    wr_valid = 1'b1;
    wr_data  = d;
    acc      = wr_ready;
    if (acc) sb.push_back(d);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm, input int max);
    int c;
    c = 0;
    while ((sb.size() != 0 || tx_start) && c < max) begin
      @(posedge clk);
      #1;
      c++;
    end
    check(nm, {31'd0, (sb.size() != 0 || tx_start)}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int f0, peak, rises, c, n;
    logic prev;

    tbl[0]  = '{1'b1, 8'hA5, 1'b0, mk(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 5'd1)};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, mk(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 5'd0)};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, mk(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 5'd0)};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, mk(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 5'd0)};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, mk(1'b0, 8'hA5, 1'b0, 1'b1, 1'b0, 5'd0)};
    tbl[5]  = '{1'b1, 8'h3C, 1'b0, mk(1'b0, 8'hA5, 1'b0, 1'b0, 1'b0, 5'd1)};
    tbl[6]  = '{1'b1, 8'h7E, 1'b0, mk(1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 5'd1)};
    tbl[7]  = '{1'b1, 8'h11, 1'b1, mk(1'b1, 8'h7E, 1'b1, 1'b0, 1'b0, 5'd1)};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, mk(1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 5'd0)};
    tbl[9]  = '{1'b1, 8'h22, 1'b1, mk(1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 5'd1)};
    tbl[10] = '{1'b0, 8'h00, 1'b0, mk(1'b1, 8'h22, 1'b1, 1'b1, 1'b0, 5'd0)};
    tbl[11] = '{1'b0, 8'h00, 1'b1, mk(1'b0, 8'h22, 1'b0, 1'b1, 1'b0, 5'd0)};

    aresetn  = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    man_done = 1'b0;
    tx_auto  = 1'b0;
`ifdef UART_TX_FEEDER_FLUSH_EN
    flush    = 1'b0;
`endif
    #1 aresetn = 1'b0;
    #2 check("reset_state", {14'd0, outs_now()}, {14'd0, mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0)});
    @(negedge clk);
    aresetn = 1'b1;
    @(posedge clk);
    #1;

    // Cycle-by-cycle vectors with manual done: single byte, ignored done, same-cycle events
    for (int i = 0; i < 12; i++) begin
      wr_valid = tbl[i].v;
      wr_data  = tbl[i].d;
      man_done = tbl[i].done;
      @(posedge clk);
      #1;
      wr_valid = 1'b0;
      man_done = 1'b0;
      check($sformatf("vec%0d", i), {14'd0, outs_now()}, {14'd0, tbl[i].exp});
    end

    // Burst 0x01..0x05
    tx_auto = 1'b1;
    f0 = frames; peak = 0; rises = 0; prev = tx_start;
    for (int i = 1; i <= 5; i++) begin
      write_byte(8'(i), acc);
      if (int'(level) > peak) peak = int'(level);
      if (tx_start && !prev) rises++;
      prev = tx_start;
    end
    c = 0;
    while ((sb.size() != 0 || tx_start) && c < 300) begin
      @(posedge clk);
      #1;
      c++;
      if (tx_start && !prev) rises++;
      prev = tx_start;
    end
    check("burst_drain", {31'd0, (sb.size() != 0 || tx_start)}, 32'd0);
    check("burst_peak_level", peak, 4);
    check("burst_start_rises", rises, 1);
    check("burst_frames", frames - f0, 5);

    // Full FIFO with done held low
    tx_auto = 1'b0;
    n = 0;
    for (int i = 0; i < 17; i++) begin
      write_byte(8'(8'h40 + i), acc);
      if (acc) n++;
    end
    check("full_accepted", n, 17);
    check("full_state", {14'd0, outs_now()}, {14'd0, mk(1'b1, 8'h40, 1'b1, 1'b0, 1'b1, 5'd16)});
    write_byte(8'hEE, acc);
    check("full_18th_rejected", {31'd0, acc}, 32'd0);
    check("full_level_hold", {27'd0, level}, 32'd16);
    check("full_head", {24'd0, tx_data}, {24'd0, sb.pop_front()});
    man_done = 1'b1;
    @(posedge clk);
    #1;
    man_done = 1'b0;
    check("full_after_done", {14'd0, outs_now()}, {14'd0, mk(1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 5'd15)});
    tx_auto = 1'b1;
    wait_drain("full_drain", 600);

    // Wrap: 40 bytes with a random valid pattern
    f0 = frames;
    n = 0; c = 0;
    while (n < 40 && c < 2000) begin
      c++;
      if ($urandom_range(0, 2) != 0) begin
        write_byte(8'($urandom_range(0, 255)), acc);
        if (acc) n++;
      end else begin
        @(posedge clk);
        #1;
      end
    end
    check("wrap_written", n, 40);
    wait_drain("wrap_drain", 1000);
    check("wrap_frames", frames - f0, 40);

    // Reset during the 3rd byte of a 6-byte burst
    f0 = frames;
    for (int i = 0; i < 6; i++) write_byte(8'(8'hB0 + i), acc);
    c = 0;
    while (frames < f0 + 3 && c < 300) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("reset_reach_3rd", {31'd0, (frames >= f0 + 3)}, 32'd1);
    @(posedge clk);
    #3;
    aresetn = 1'b0;
    sb.delete();
    #1;
    check("reset_midframe", {14'd0, outs_now()}, {14'd0, mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0)});
    @(negedge clk);
    aresetn = 1'b1;
    rises = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (tx_start) rises++;
    end
    check("no_tx_after_reset", rises, 0);
    check("level_after_reset", {27'd0, level}, 32'd0);

`ifdef UART_TX_FEEDER_FLUSH_EN
    // Flush with 5 queued and 1 in flight
    tx_auto = 1'b0;
    for (int i = 0; i < 6; i++) write_byte(8'(8'hC0 + i), acc);
    check("flush_pre", {14'd0, outs_now()}, {14'd0, mk(1'b1, 8'hC0, 1'b1, 1'b0, 1'b0, 5'd5)});
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 8'h99;
    #1;
    check("flush_ready_low", {31'd0, wr_ready}, 32'd0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    wr_valid = 1'b0;
    check("flush_cleared", {14'd0, outs_now()}, {14'd0, mk(1'b1, 8'hC0, 1'b1, 1'b1, 1'b0, 5'd0)});
    man_done = 1'b1;
    @(posedge clk);
    #1;
    man_done = 1'b0;
    check("flush_after_done", {14'd0, outs_now()}, {14'd0, mk(1'b0, 8'hC0, 1'b0, 1'b1, 1'b0, 5'd0)});
    rises = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (tx_start) rises++;
    end
    check("flush_no_more_frames", rises, 0);
    sb.delete();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
